// File: rtl/regfile.sv
// MIPS general-purpose register file: two combinational read ports with
// same-cycle write-back bypass, one write port, r0 hardwired to zero.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    // Index 0 has no storage; reads of r0 are forced to zero below.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // Next-state for each register: take wdata on an addressed write.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we && (waddr == ADDR_WIDTH'(i))) begin
                regs_d[i] = wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage: asynchronous reset beats any write pending in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: reset, disable and r0 give zero; a matching write bypasses storage.
    always_comb begin
        rdata1 = {DATA_WIDTH{1'b0}};
        if (rst || !re1 || (raddr1 == {ADDR_WIDTH{1'b0}})) begin
            rdata1 = {DATA_WIDTH{1'b0}};
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_q[raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        rdata2 = {DATA_WIDTH{1'b0}};
        if (rst || !re2 || (raddr2 == {ADDR_WIDTH{1'b0}})) begin
            rdata2 = {DATA_WIDTH{1'b0}};
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, randomized traffic
// against an array model, and asynchronous reset sequences.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [11];

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: the architectural view of the register file.
    function automatic logic [31:0] ref_read(input logic r, input logic [4:0] a);
        if (rst || !r || a == 5'd0) return 32'd0;
        if (we && waddr == a) return wdata;
        return model[a];
    endfunction

    function automatic void model_commit();
        if (!rst && we && waddr != 5'd0) model[waddr] = wdata;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        //                we    wa     wdata          re1   ra1    re2   ra2    exp1           exp2
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd7,  1'b1, 5'd7,  32'h0,        32'h12345678};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        32'h12345678};
        vecs[5]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd9,  1'b1, 5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  1'b1, 5'd9,  32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 5'd9,  32'h00001111, 1'b1, 5'd9,  1'b1, 5'd5,  32'h00001111, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd31, 32'h00001111, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 1'b0, 5'd31, 32'hCAFEF00D, 32'h0};
        vecs[10] = '{1'b0, 5'd31, 32'h00000001, 1'b1, 5'd31, 1'b1, 5'd1,  32'hCAFEF00D, 32'h0};

        // Power-on reset with a write attempt pending: outputs zero, write lost.
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #2;
        check("reset_rd1", rdata1, 32'h0);
        check("reset_rd2", rdata2, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0;
        #2;
        check("write_during_reset_lost", rdata1, 32'h0);

        // Directed table: each vector is one cycle, writes commit at the edge.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re1 = vecs[i].re1; raddr1 = vecs[i].ra1;
            re2 = vecs[i].re2; raddr2 = vecs[i].ra2;
            #3;
            check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
            model_commit();
        end

        // Randomized traffic with biased address collisions.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            we = 1'($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            re1 = 1'($urandom_range(0, 7) != 0);
            re2 = 1'($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #3;
            check($sformatf("rand%0d_rd1", i), rdata1, ref_read(re1, raddr1));
            check($sformatf("rand%0d_rd2", i), rdata2, ref_read(re2, raddr2));
            model_commit();
        end

        // Populate reg 3, then hit reset mid-cycle while it is being rewritten.
        @(posedge clk); #1;
        we = 1'b1; waddr = 5'd3; wdata = 32'h33333333; re1 = 1'b0; re2 = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #2;
        check("reg3_before_reset", rdata1, 32'h33333333);
        @(posedge clk); #1;
        we = 1'b1; waddr = 5'd3; wdata = 32'h44444444;
        #2;
        check("reg3_bypass_pre_reset", rdata2, 32'h44444444);
        rst = 1'b1;
        #1;
        check("async_reset_rd1", rdata1, 32'h0);
        check("async_reset_rd2", rdata2, 32'h0);
        @(posedge clk); #1;
        check("reset_held_rd1", rdata1, 32'h0);
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #2;
        check("reg3_after_reset", rdata1, 32'h0);

        // Every register reads zero on both ports after reset.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            raddr1 = 5'(i); raddr2 = 5'(32 - i);
            #1;
            check($sformatf("post_reset_r%0d_p1", i), rdata1, 32'h0);
            check($sformatf("post_reset_r%0d_p2", 32 - i), rdata2, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
